// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator unit: op encodings and stack sizing helper.
package ac_pkg;

  localparam int unsigned AC_OP_W = 3;

  localparam logic [AC_OP_W-1:0] AC_OP_HOLD  = 3'b000;
  localparam logic [AC_OP_W-1:0] AC_OP_LOAD  = 3'b001;
  localparam logic [AC_OP_W-1:0] AC_OP_CLEAR = 3'b010;
  localparam logic [AC_OP_W-1:0] AC_OP_INC   = 3'b011;
  localparam logic [AC_OP_W-1:0] AC_OP_DEC   = 3'b100;
  localparam logic [AC_OP_W-1:0] AC_OP_ADD   = 3'b101;
  localparam logic [AC_OP_W-1:0] AC_OP_SHR   = 3'b110;
  localparam logic [AC_OP_W-1:0] AC_OP_SHL   = 3'b111;

  // Width needed to hold a count from 0 up to and including depth.
  function automatic int unsigned ac_cnt_w(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ac_accumulator_unit_if.sv
// Operation/result bundle between the control unit and the accumulator unit.
interface ac_accumulator_unit_if #(
  parameter int unsigned WIDTH = 16
);
  import ac_pkg::*;

  logic                op_en;
  logic [AC_OP_W-1:0]  op_sel;
  logic [WIDTH-1:0]    reg_input;
  logic                push;
  logic                pop;
  logic [WIDTH-1:0]    AC_data;
  logic                Z_Flag;
  logic                N_Flag;
  logic                C_Flag;
  logic                stack_full;
  logic                stack_empty;
  logic                stack_err;

  modport master (
    output op_en, op_sel, reg_input, push, pop,
    input  AC_data, Z_Flag, N_Flag, C_Flag, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  op_en, op_sel, reg_input, push, pop,
    output AC_data, Z_Flag, N_Flag, C_Flag, stack_full, stack_empty, stack_err
  );

endinterface

// File: rtl/ac_lifo.sv
// Save/restore LIFO for the accumulator: register array plus occupancy count.
module ac_lifo
  import ac_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             pop_ok,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int unsigned CNT_W = ac_cnt_w(STACK_DEPTH);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STACK_DEPTH);

  logic [WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q, err_q, err_d;
  logic             push_ok;
  logic [IDX_W-1:0] wr_idx, top_idx;

  // Simultaneous push and pop cancel out: no stack change, no error.
  assign push_ok = push && !pop && (count_q != CNT_MAX);
  assign pop_ok  = pop && !push && (count_q != '0);
  assign wr_idx  = IDX_W'(count_q);
  assign top_idx = IDX_W'(count_q - CNT_W'(1));
  assign rd_data = mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (push_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok) begin
      count_d = count_q - CNT_W'(1);
    end else if (push != pop) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CNT_MAX);
      empty_q <= (count_d == '0);
      err_q   <= err_d;
    end
  end

  // Storage is intentionally not reset; the count alone defines validity.
  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;

endmodule

// File: rtl/ac_accumulator_unit.sv
// Accumulator with registered Z/N/C flags, optional saturation and a save/restore LIFO.
module ac_accumulator_unit
  import ac_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned SATURATE    = 1
) (
  input logic                   Clk,
  input logic                   Rst,
  ac_accumulator_unit_if.slave  bus
);

  logic [WIDTH-1:0] ac_q, ac_d;
  logic             z_q, n_q, c_q, c_d;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] stk_rd_data;
  logic             stk_pop_ok;

  ac_lifo #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_lifo (
    .Clk     (Clk),
    .Rst     (Rst),
    .push    (bus.push),
    .pop     (bus.pop),
    .wr_data (ac_q),
    .rd_data (stk_rd_data),
    .pop_ok  (stk_pop_ok),
    .full    (bus.stack_full),
    .empty   (bus.stack_empty),
    .err     (bus.stack_err)
  );

  assign addend = (bus.op_sel == AC_OP_ADD) ? bus.reg_input : WIDTH'(1);
  assign sum    = {1'b0, ac_q} + {1'b0, addend};
  assign diff   = {1'b0, ac_q} - (WIDTH + 1)'(1);

  always_comb begin
    ac_d = ac_q;
    c_d  = c_q;
    if (stk_pop_ok) begin
      ac_d = stk_rd_data;
      c_d  = 1'b0;
    end else if (bus.pop && !bus.push) begin
      // Pop on an empty stack suppresses the op entirely.
    end else if (bus.op_en) begin
      unique case (bus.op_sel)
        AC_OP_HOLD: ;
        AC_OP_LOAD: begin
          ac_d = bus.reg_input;
          c_d  = 1'b0;
        end
        AC_OP_CLEAR: begin
          ac_d = '0;
          c_d  = 1'b0;
        end
        AC_OP_INC, AC_OP_ADD: begin
          c_d  = sum[WIDTH];
          ac_d = ((SATURATE != 0) && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        end
        AC_OP_DEC: begin
          c_d  = diff[WIDTH];
          ac_d = ((SATURATE != 0) && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
        end
        AC_OP_SHR: begin
          c_d  = ac_q[0];
          ac_d = {1'b0, ac_q[WIDTH-1:1]};
        end
        AC_OP_SHL: begin
          c_d  = ac_q[WIDTH-1];
          ac_d = {ac_q[WIDTH-2:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

  // Flags are derived from ac_d so they land in the same edge as the value.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ac_q <= '0;
      z_q  <= 1'b1;
      n_q  <= 1'b0;
      c_q  <= 1'b0;
    end else begin
      ac_q <= ac_d;
      z_q  <= (ac_d == '0);
      n_q  <= ac_d[WIDTH-1];
      c_q  <= c_d;
    end
  end

  assign bus.AC_data = ac_q;
  assign bus.Z_Flag  = z_q;
  assign bus.N_Flag  = n_q;
  assign bus.C_Flag  = c_q;

endmodule

// File: tb/tb_ac_accumulator_unit.sv
// Directed bench: a saturating and a wrapping instance driven with identical stimulus.
module tb_ac_accumulator_unit;
  import ac_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        op_en = 1'b0;
  logic [2:0]  op_sel = AC_OP_HOLD;
  logic [15:0] reg_input = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 Clk = ~Clk;

  ac_accumulator_unit_if #(.WIDTH(16)) bus_s ();
  ac_accumulator_unit_if #(.WIDTH(16)) bus_w ();

  assign bus_s.op_en = op_en;  assign bus_w.op_en = op_en;
  assign bus_s.op_sel = op_sel;  assign bus_w.op_sel = op_sel;
  assign bus_s.reg_input = reg_input;  assign bus_w.reg_input = reg_input;
  assign bus_s.push = push;  assign bus_w.push = push;
  assign bus_s.pop = pop;  assign bus_w.pop = pop;

  ac_accumulator_unit #(.WIDTH(16), .STACK_DEPTH(4), .SATURATE(1)) u_sat (
    .Clk (Clk), .Rst (Rst), .bus (bus_s.slave)
  );
  ac_accumulator_unit #(.WIDTH(16), .STACK_DEPTH(4), .SATURATE(0)) u_wrap (
    .Clk (Clk), .Rst (Rst), .bus (bus_w.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic en, input logic [2:0] sel, input logic [15:0] d,
                      input logic pu, input logic po);
    op_en = en; op_sel = sel; reg_input = d; push = pu; pop = po;
    @(posedge Clk);
    #1;
    op_en = 1'b0; op_sel = AC_OP_HOLD; push = 1'b0; pop = 1'b0;
  endtask

  task automatic op(input logic [2:0] sel, input logic [15:0] d);
    step(1'b1, sel, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, AC_OP_HOLD, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_s(input string tag, input logic [15:0] ac, input logic z, input logic n,
                       input logic c);
    check_eq({tag, ".sat.ac"}, 32'(bus_s.AC_data), 32'(ac));
    check_eq({tag, ".sat.znc"}, {29'd0, bus_s.Z_Flag, bus_s.N_Flag, bus_s.C_Flag}, {29'd0, z, n, c});
  endtask

  task automatic chk_w(input string tag, input logic [15:0] ac, input logic z, input logic n,
                       input logic c);
    check_eq({tag, ".wrap.ac"}, 32'(bus_w.AC_data), 32'(ac));
    check_eq({tag, ".wrap.znc"}, {29'd0, bus_w.Z_Flag, bus_w.N_Flag, bus_w.C_Flag}, {29'd0, z, n, c});
  endtask

  // Stack status as {full, empty, err}.
  task automatic chk_stk(input string tag, input logic f, input logic e, input logic err);
    check_eq({tag, ".stk"}, {29'd0, bus_s.stack_full, bus_s.stack_empty, bus_s.stack_err},
             {29'd0, f, e, err});
  endtask

  logic [15:0] vals [4];

  initial begin
    vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033; vals[3] = 16'h0044;

    Rst = 1'b1;
    idle();
    idle();
    Rst = 1'b0;
    idle();
    chk_s("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_w("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_stk("reset", 1'b0, 1'b1, 1'b0);

    // Increment into and past the top
    op(AC_OP_LOAD, 16'hFFFE);
    op(AC_OP_INC, 16'h0);
    chk_s("inc1", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    chk_w("inc1", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    op(AC_OP_INC, 16'h0);
    chk_s("inc2", 16'hFFFF, 1'b0, 1'b1, 1'b1);
    chk_w("inc2", 16'h0000, 1'b1, 1'b0, 1'b1);

    // Decrement into and past zero
    op(AC_OP_LOAD, 16'h0001);
    op(AC_OP_DEC, 16'h0);
    chk_s("dec1", 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_w("dec1", 16'h0000, 1'b1, 1'b0, 1'b0);
    op(AC_OP_DEC, 16'h0);
    chk_s("dec2", 16'h0000, 1'b1, 1'b0, 1'b1);
    chk_w("dec2", 16'hFFFF, 1'b0, 1'b1, 1'b1);

    // Shifts
    op(AC_OP_LOAD, 16'h8001);
    op(AC_OP_SHR, 16'h0);
    chk_s("shr", 16'h4000, 1'b0, 1'b0, 1'b1);
    op(AC_OP_SHL, 16'h0);
    chk_s("shl", 16'h8000, 1'b0, 1'b1, 1'b0);

    // Add without and with overflow
    op(AC_OP_LOAD, 16'h1234);
    op(AC_OP_ADD, 16'h0F0F);
    chk_s("add", 16'h2143, 1'b0, 1'b0, 1'b0);
    op(AC_OP_LOAD, 16'hF000);
    op(AC_OP_ADD, 16'h2000);
    chk_s("add_ovf", 16'hFFFF, 1'b0, 1'b1, 1'b1);
    chk_w("add_ovf", 16'h1000, 1'b0, 1'b0, 1'b1);

    // op_en low with an op selected, then explicit clear
    step(1'b0, AC_OP_INC, 16'h0, 1'b0, 1'b0);
    chk_s("op_en0", 16'hFFFF, 1'b0, 1'b1, 1'b1);
    op(AC_OP_CLEAR, 16'h0);
    chk_s("clear", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Fill the stack; each push saves the pre-update AC while a load runs alongside
    op(AC_OP_LOAD, vals[0]);
    for (int i = 1; i < 4; i++) begin
      step(1'b1, AC_OP_LOAD, vals[i], 1'b1, 1'b0);
      chk_s($sformatf("push%0d", i), vals[i], 1'b0, 1'b0, 1'b0);
    end
    chk_stk("push3", 1'b0, 1'b0, 1'b0);
    step(1'b0, AC_OP_HOLD, 16'h0, 1'b1, 1'b0);
    chk_stk("push4", 1'b1, 1'b0, 1'b0);
    step(1'b0, AC_OP_HOLD, 16'h0, 1'b1, 1'b0);
    chk_stk("push_full", 1'b1, 1'b0, 1'b1);
    idle();
    chk_stk("err_pulse", 1'b1, 1'b0, 1'b0);

    // Drain in reverse order; pop clears C
    op(AC_OP_LOAD, 16'hFFFF);
    op(AC_OP_INC, 16'h0);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, AC_OP_HOLD, 16'h0, 1'b0, 1'b1);
      chk_s($sformatf("pop%0d", i), vals[i], 1'b0, 1'b0, 1'b0);
    end
    chk_stk("pop_last", 1'b0, 1'b1, 1'b0);
    step(1'b1, AC_OP_LOAD, 16'h0099, 1'b0, 1'b1);
    chk_s("pop_empty", 16'h0011, 1'b0, 1'b0, 1'b0);
    chk_stk("pop_empty", 1'b0, 1'b1, 1'b1);

    // Pop wins over a same-cycle load
    op(AC_OP_LOAD, 16'h0066);
    step(1'b0, AC_OP_HOLD, 16'h0, 1'b1, 1'b0);
    op(AC_OP_LOAD, 16'h0077);
    step(1'b1, AC_OP_LOAD, 16'h0055, 1'b0, 1'b1);
    chk_s("pop_vs_load", 16'h0066, 1'b0, 1'b0, 1'b0);
    chk_stk("pop_vs_load", 1'b0, 1'b1, 1'b0);

    // Push and pop together: stack untouched, op still applies
    op(AC_OP_LOAD, 16'h0010);
    step(1'b0, AC_OP_HOLD, 16'h0, 1'b1, 1'b0);
    step(1'b1, AC_OP_INC, 16'h0, 1'b1, 1'b1);
    chk_s("push_pop", 16'h0011, 1'b0, 1'b0, 1'b0);
    chk_stk("push_pop", 1'b0, 1'b0, 1'b0);
    step(1'b0, AC_OP_HOLD, 16'h0, 1'b0, 1'b1);
    chk_s("push_pop_after", 16'h0010, 1'b0, 1'b0, 1'b0);
    chk_stk("push_pop_after", 1'b0, 1'b1, 1'b0);

    // Reset discards stack contents
    step(1'b0, AC_OP_HOLD, 16'h0, 1'b1, 1'b0);
    step(1'b0, AC_OP_HOLD, 16'h0, 1'b1, 1'b0);
    Rst = 1'b1;
    idle();
    Rst = 1'b0;
    chk_s("rst_mid", 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_stk("rst_mid", 1'b0, 1'b1, 1'b0);
    step(1'b0, AC_OP_HOLD, 16'h0, 1'b0, 1'b1);
    chk_s("rst_pop", 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_stk("rst_pop", 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
